// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
//   state_t      : sequencer states
//   CAUSE_*      : encodings reported on rst_cause
//   COUNT_W/MAX  : rst_count width and saturation value
//   cnt_width()  : counter width able to hold 0..max_val (never below 1)
package reset_seq_pkg;

  typedef enum logic [1:0] {
    POR_WAIT = 2'd0,
    ASSERT   = 2'd1,
    RELEASE  = 2'd2,
    RUN      = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_REQ = 2'b01;
  localparam logic [1:0] CAUSE_PER = 2'b10;

  localparam int unsigned COUNT_W = 8;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/reset_seq_if.sv
// Request/status bundle between the reset sequencer and the rest of the chip.
//   sw_rst_req  : asynchronous reset request (button/software)
//   periodic_en : enables the periodic reset timer
//   rst_out_n   : per-subsystem active-low resets
//   rst_done    : all resets released
//   rst_cause   : cause of the last sequence
//   rst_count   : triggered resets since rst_n, saturating
// slave = the sequencer, master = the block driving requests and reading status.
interface reset_seq_if #(
  parameter int unsigned N_OUT = 4
);
  import reset_seq_pkg::*;

  logic                  sw_rst_req;
  logic                  periodic_en;
  logic [N_OUT-1:0]      rst_out_n;
  logic                  rst_done;
  logic [1:0]            rst_cause;
  logic [COUNT_W-1:0]    rst_count;

  modport master (
    output sw_rst_req, periodic_en,
    input  rst_out_n, rst_done, rst_cause, rst_count
  );

  modport slave (
    input  sw_rst_req, periodic_en,
    output rst_out_n, rst_done, rst_cause, rst_count
  );

endinterface

// File: rtl/reset_req_filter.sv
// Synchronizes sw_rst_req and turns each sufficiently long press into a
// single one-cycle trig_req pulse.
//   clk_100    : system clock
//   rst_n      : asynchronous active-low reset
//   sw_rst_req : raw asynchronous request
//   trig_req   : one-cycle pulse once REQ_HOLD synchronized-high cycles are seen
module reset_req_filter
  import reset_seq_pkg::*;
#(
  parameter int unsigned REQ_HOLD    = 100,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic clk_100,
  input  logic rst_n,
  input  logic sw_rst_req,
  output logic trig_req
);

  localparam int unsigned HOLD_W = cnt_width(REQ_HOLD);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [HOLD_W-1:0]      hold_q;
  logic                   req_s;

  assign req_s = sync_q[SYNC_STAGES-1];

  // Metastability synchronizer chain
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], sw_rst_req};
  end

  // Hold counter parks at REQ_HOLD while the press lasts, so one press fires once
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      trig_req <= 1'b0;
    end else begin
      trig_req <= 1'b0;
      if (!req_s) begin
        hold_q <= '0;
      end else if (hold_q != HOLD_W'(REQ_HOLD)) begin
        hold_q   <= hold_q + HOLD_W'(1);
        trig_req <= (hold_q == HOLD_W'(REQ_HOLD - 1));
      end
    end
  end

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: holds all reset outputs through a power-on delay, releases
// them one at a time STAGGER cycles apart, and re-runs the sequence on a
// filtered request or on the periodic timer.
//   clk_100 : system clock
//   rst_n   : asynchronous active-low reset (clears every flop)
//   bus     : reset_seq_if.slave (request inputs, reset outputs and status)
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int unsigned N_OUT         = 4,
  parameter int unsigned POR_CYCLES    = 10000,
  parameter int unsigned MIN_ASSERT    = 100,
  parameter int unsigned STAGGER       = 16,
  parameter int unsigned REQ_HOLD      = 100,
  parameter int unsigned SYNC_STAGES   = 3,
  parameter int unsigned PERIOD_CYCLES = 400000000
) (
  input  logic        clk_100,
  input  logic        rst_n,
  reset_seq_if.slave  bus
);

  localparam int unsigned HOLD_MAX  = (POR_CYCLES > MIN_ASSERT) ? POR_CYCLES : MIN_ASSERT;
  localparam int unsigned PHASE_MAX = ((HOLD_MAX > STAGGER) ? HOLD_MAX : STAGGER) - 1;
  localparam int unsigned PHASE_W   = cnt_width(PHASE_MAX);
  localparam int unsigned IDX_W     = cnt_width(N_OUT);
  localparam int unsigned PER_W     = cnt_width(PERIOD_CYCLES - 1);

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [PER_W-1:0]   per_q,   per_d;
  logic [N_OUT-1:0]   out_q,   out_d;
  logic               done_q,  done_d;
  logic [1:0]         cause_q, cause_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic trig_req;
  logic trig_per_c;
  logic trig_c;

  reset_req_filter #(
    .REQ_HOLD    (REQ_HOLD),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_req_filter (
    .clk_100    (clk_100),
    .rst_n      (rst_n),
    .sw_rst_req (bus.sw_rst_req),
    .trig_req   (trig_req)
  );

  // Triggers are only honoured once the outputs have started releasing
  assign trig_per_c = (state_q == RUN) && bus.periodic_en &&
                      (per_q == PER_W'(PERIOD_CYCLES - 1));
  assign trig_c     = ((state_q == RUN) || (state_q == RELEASE)) &&
                      (trig_req || trig_per_c);

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    per_d   = '0;
    out_d   = out_q;
    done_d  = done_q;
    cause_d = cause_q;
    count_d = count_q;

    if (trig_c) begin
      state_d = ASSERT;
      phase_d = '0;
      idx_d   = '0;
      out_d   = '0;
      done_d  = 1'b0;
      cause_d = trig_req ? CAUSE_REQ : CAUSE_PER;
      if (count_q != COUNT_MAX) count_d = count_q + COUNT_W'(1);
    end else begin
      case (state_q)
        POR_WAIT: begin
          if (phase_q == PHASE_W'(POR_CYCLES - 1)) begin
            state_d = RELEASE;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PHASE_W'(1);
          end
        end
        ASSERT: begin
          if (phase_q == PHASE_W'(MIN_ASSERT - 1)) begin
            state_d = RELEASE;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PHASE_W'(1);
          end
        end
        RELEASE: begin
          // idx_q == N_OUT means the last bit went high last cycle
          if (idx_q == IDX_W'(N_OUT)) begin
            state_d = RUN;
            done_d  = 1'b1;
            phase_d = '0;
          end else if (phase_q == PHASE_W'(STAGGER - 1)) begin
            phase_d = '0;
            idx_d   = idx_q + IDX_W'(1);
            for (int k = 0; k < N_OUT; k++) begin
              if (idx_q == IDX_W'(k)) out_d[k] = 1'b1;
            end
          end else begin
            phase_d = phase_q + PHASE_W'(1);
          end
        end
        RUN: begin
          if (bus.periodic_en) per_d = per_q + PER_W'(1);
        end
        default: state_d = POR_WAIT;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= POR_WAIT;
      phase_q <= '0;
      idx_q   <= '0;
      per_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      cause_q <= CAUSE_POR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      per_q   <= per_d;
      out_q   <= out_d;
      done_q  <= done_d;
      cause_q <= cause_d;
      count_q <= count_d;
    end
  end

  assign bus.rst_out_n = out_q;
  assign bus.rst_done  = done_q;
  assign bus.rst_cause = cause_q;
  assign bus.rst_count = count_q;

endmodule

// File: tb/tb_reset_seq.sv
// Testbench for reset_seq: directed scenarios plus randomized requests,
// checked every cycle against a timestamp-based reference model.
module tb_reset_seq;

  localparam int N_OUT         = 3;
  localparam int POR_CYCLES    = 20;
  localparam int MIN_ASSERT    = 8;
  localparam int STAGGER       = 4;
  localparam int REQ_HOLD      = 5;
  localparam int SYNC_STAGES   = 2;
  localparam int PERIOD_CYCLES = 50;

  logic clk_100 = 1'b0;
  logic rst_n;

  reset_seq_if #(.N_OUT(N_OUT)) bus ();

  reset_seq #(
    .N_OUT         (N_OUT),
    .POR_CYCLES    (POR_CYCLES),
    .MIN_ASSERT    (MIN_ASSERT),
    .STAGGER       (STAGGER),
    .REQ_HOLD      (REQ_HOLD),
    .SYNC_STAGES   (SYNC_STAGES),
    .PERIOD_CYCLES (PERIOD_CYCLES)
  ) dut (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_100 = ~clk_100;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a sequence is described by the cycle its hold phase began
  // and the hold length; every output follows from those two numbers.
  int m_now;        // cycles since rst_n deassert (cycle 0 = first cycle)
  int m_seq_start;
  int m_hold;
  int m_cause;
  int m_count;
  int m_streak;     // consecutive synchronized-high cycles so far
  bit m_req_trig;   // request trigger active in the current cycle
  int m_per_cnt;    // consecutive RUN cycles with periodic_en high
  bit raw_q[$];     // raw_q[c] = sw_rst_req sampled at the edge ending cycle c

  function automatic void model_reset();
    m_now       = 0;
    m_seq_start = 0;
    m_hold      = POR_CYCLES;
    m_cause     = 0;
    m_count     = 0;
    m_streak    = 0;
    m_req_trig  = 1'b0;
    m_per_cnt   = 0;
    raw_q.delete();
  endfunction

  function automatic int rel_start();
    return m_seq_start + m_hold;
  endfunction

  function automatic logic [N_OUT-1:0] exp_out();
    logic [N_OUT-1:0] v;
    for (int k = 0; k < N_OUT; k++) v[k] = (m_now >= rel_start() + (k + 1) * STAGGER);
    return v;
  endfunction

  function automatic logic exp_done();
    return m_now >= rel_start() + N_OUT * STAGGER + 1;
  endfunction

  function automatic void model_step();
    int  t0;
    bit  in_run;
    bit  per_fire;
    bit  sv;
    t0     = rel_start();
    in_run = (m_now >= t0 + N_OUT * STAGGER + 1);
    if (in_run && bus.periodic_en) m_per_cnt++;
    else                           m_per_cnt = 0;
    per_fire = (m_per_cnt == PERIOD_CYCLES);
    if (m_now >= t0 && (m_req_trig || per_fire)) begin
      m_seq_start = m_now + 1;
      m_hold      = MIN_ASSERT;
      m_cause     = m_req_trig ? 1 : 2;
      if (m_count < 255) m_count++;
    end
    raw_q.push_back(bus.sw_rst_req);
    sv         = (m_now >= SYNC_STAGES) ? raw_q[m_now - SYNC_STAGES] : 1'b0;
    m_streak   = sv ? m_streak + 1 : 0;
    m_req_trig = (m_streak == REQ_HOLD);
    m_now++;
  endfunction

  always @(negedge rst_n) model_reset();

  always @(posedge clk_100) if (rst_n === 1'b1) model_step();

  // Every-cycle comparison against the model
  always @(negedge clk_100) begin
    if (rst_n === 1'b1) begin
      check_val("cyc_rst_out_n", 32'(bus.rst_out_n), 32'(exp_out()));
      check_val("cyc_rst_done",  32'(bus.rst_done),  32'(exp_done()));
      check_val("cyc_rst_cause", 32'(bus.rst_cause), 32'(m_cause));
      check_val("cyc_rst_count", 32'(bus.rst_count), 32'(m_count));
    end
  end

  task automatic at(input int n);
    int guard;
    guard = 0;
    while (m_now < n && guard < 2000) begin
      @(negedge clk_100);
      guard++;
    end
    check_val("reach_cycle", 32'(m_now), 32'(n));
  endtask

  task automatic wait_done(input logic v, input int budget);
    int guard;
    guard = 0;
    while (bus.rst_done !== v && guard < budget) begin
      @(negedge clk_100);
      guard++;
    end
    check_val("wait_rst_done", 32'(bus.rst_done), 32'(v));
  endtask

  task automatic check_outs(input string tag, input logic [N_OUT-1:0] o, input logic d);
    check_val({tag, "_out"},  32'(bus.rst_out_n), 32'(o));
    check_val({tag, "_done"}, 32'(bus.rst_done),  32'(d));
  endtask

  task automatic check_status(input string tag, input int cause, input int count);
    check_val({tag, "_cause"}, 32'(bus.rst_cause), 32'(cause));
    check_val({tag, "_count"}, 32'(bus.rst_count), 32'(count));
  endtask

  int press_left = 0;
  int gap_left   = 10;

  initial begin
    rst_n           = 1'b0;
    bus.sw_rst_req  = 1'b0;
    bus.periodic_en = 1'b0;
    model_reset();
    #1;
    check_outs("reset", '0, 1'b0);
    check_status("reset", 0, 0);
    repeat (3) @(negedge clk_100);
    rst_n = 1'b1;

    // Power-up release order
    at(23); check_outs("por23", 3'b000, 1'b0);
    at(24); check_outs("por24", 3'b001, 1'b0);
    at(28); check_outs("por28", 3'b011, 1'b0);
    at(32); check_outs("por32", 3'b111, 1'b0);
    at(33); check_outs("por33", 3'b111, 1'b1); check_status("por33", 0, 0);

    // Short press (4 synchronized cycles) must not trigger
    at(40); bus.sw_rst_req = 1'b1;
    at(44); bus.sw_rst_req = 1'b0;
    at(60); check_outs("short", 3'b111, 1'b1); check_status("short", 0, 0);

    // Long press triggers once, even when held
    bus.sw_rst_req = 1'b1;
    at(67); check_outs("req67", 3'b111, 1'b1);
    at(68); check_outs("req68", 3'b000, 1'b0); check_status("req68", 1, 1);
    at(79); check_outs("req79", 3'b000, 1'b0);
    at(80); check_outs("req80", 3'b001, 1'b0);
    at(84); check_outs("req84", 3'b011, 1'b0);
    at(88); check_outs("req88", 3'b111, 1'b0);
    at(89); check_outs("req89", 3'b111, 1'b1);
    at(130); check_status("held", 1, 1);
    bus.sw_rst_req = 1'b0;

    // Periodic trigger and repeat
    at(140); bus.periodic_en = 1'b1;
    at(189); check_outs("per189", 3'b111, 1'b1);
    at(190); check_outs("per190", 3'b000, 1'b0); check_status("per190", 2, 2);
    at(211); check_outs("per211", 3'b111, 1'b1);
    at(260); check_outs("per260", 3'b111, 1'b1);
    at(261); check_outs("per261", 3'b000, 1'b0); check_status("per261", 2, 3);
    at(270); bus.periodic_en = 1'b0;
    at(470); check_outs("per_off", 3'b111, 1'b1); check_status("per_off", 2, 3);

    // Request landing 6 cycles into RELEASE
    at(480); bus.sw_rst_req = 1'b1;
    at(488); check_outs("rel488", 3'b000, 1'b0); check_status("rel488", 1, 4);
    at(490); bus.sw_rst_req = 1'b0;
    at(495); bus.sw_rst_req = 1'b1;
    at(502); check_outs("rel502", 3'b001, 1'b0);
    at(503); check_outs("rel503", 3'b000, 1'b0); check_status("rel503", 1, 5);
    at(505); bus.sw_rst_req = 1'b0;
    at(514); check_outs("rel514", 3'b000, 1'b0);
    at(515); check_outs("rel515", 3'b001, 1'b0);
    at(519); check_outs("rel519", 3'b011, 1'b0);
    at(523); check_outs("rel523", 3'b111, 1'b0);
    at(524); check_outs("rel524", 3'b111, 1'b1); check_status("rel524", 1, 5);

    // Asynchronous rst_n pulse between edges
    at(560);
    #2 rst_n = 1'b0;
    #1 check_outs("async", 3'b000, 1'b0); check_status("async", 0, 0);
    #1 rst_n = 1'b1;
    at(23); check_outs("repor23", 3'b000, 1'b0);
    at(24); check_outs("repor24", 3'b001, 1'b0);
    at(32); check_outs("repor32", 3'b111, 1'b0);
    at(33); check_outs("repor33", 3'b111, 1'b1); check_status("repor33", 0, 0);

    // Request and periodic expiry in the same cycle
    at(40); bus.periodic_en = 1'b1;
    at(82); bus.sw_rst_req = 1'b1;
    at(89); check_outs("both89", 3'b111, 1'b1);
    at(90); check_outs("both90", 3'b000, 1'b0); check_status("both90", 1, 1);
    at(91); bus.sw_rst_req = 1'b0; bus.periodic_en = 1'b0;
    at(112); check_outs("both112", 3'b111, 1'b1); check_status("both112", 1, 1);

    // Randomized presses, periodic toggling and occasional rst_n pulses
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk_100);
      if (bus.sw_rst_req) begin
        if (press_left == 0) begin
          bus.sw_rst_req = 1'b0;
          gap_left       = $urandom_range(1, 40);
        end else begin
          press_left--;
        end
      end else begin
        if (gap_left == 0) begin
          bus.sw_rst_req = 1'b1;
          press_left     = $urandom_range(1, 12);
        end else begin
          gap_left--;
        end
      end
      if ($urandom_range(0, 199) == 0) bus.periodic_en = ~bus.periodic_en;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        #1 check_val("rand_async_out", 32'(bus.rst_out_n), 32'(0));
        #1 rst_n = 1'b1;
      end
    end

    // Saturation of rst_count
    bus.sw_rst_req  = 1'b0;
    bus.periodic_en = 1'b0;
    repeat (60) @(negedge clk_100);
    for (int i = 0; i < 300; i++) begin
      bus.sw_rst_req = 1'b1;
      wait_done(1'b0, 40);
      bus.sw_rst_req = 1'b0;
      wait_done(1'b1, 60);
    end
    repeat (5) @(negedge clk_100);
    check_status("sat", 1, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
